// File: rtl/flash_prog.sv
// flash_prog: Wishbone-controlled program/sector-erase engine for 16-bit AMD-command NOR flash.
// Issues timed unlock/command write cycles, then polls DQ6 toggle / DQ5 until completion or timeout.
module flash_prog #(
  parameter int unsigned T_SU  = 1,
  parameter int unsigned T_WE  = 4,
  parameter int unsigned T_HLD = 2,
  parameter int unsigned T_RD  = 5,
  parameter int unsigned TMO   = 250_000_000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [2:1]  wb_adr_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic [1:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic [21:0] flash_addr_,
  input  logic [15:0] flash_data_i_,
  output logic [15:0] flash_data_o_,
  output logic        flash_data_oe_,
  output logic        flash_we_n_,
  output logic        flash_oe_n_,
  output logic        flash_ce_n_,
  output logic        flash_rst_n_
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] W_SU  = 4'd1;
  localparam logic [3:0] W_LO  = 4'd2;
  localparam logic [3:0] W_HLD = 4'd3;
  localparam logic [3:0] W_GAP = 4'd4;
  localparam logic [3:0] P_RD  = 4'd5;
  localparam logic [3:0] P_GAP = 4'd6;
  localparam logic [3:0] RST_W = 4'd7;
  localparam logic [3:0] DONE  = 4'd8;

  localparam logic [7:0]  SU_L  = 8'(T_SU - 1);
  localparam logic [7:0]  WE_L  = 8'(T_WE - 1);
  localparam logic [7:0]  HLD_L = 8'(T_HLD - 1);
  localparam logic [7:0]  RD_L  = 8'(T_RD - 1);
  localparam logic [31:0] TMO_L = 32'(TMO - 1);

  logic [3:0]  state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [2:0]  step, step_n;
  logic [31:0] tmo_cnt, tmo_n;
  logic        is_erase, is_erase_n;
  logic        f0, f0_n;
  logic        first, first_n;
  logic        extra, extra_n;
  logic        prev6, prev6_n;
  logic        busy, busy_n;
  logic        done, done_n;
  logic        err, err_n;
  logic [7:0]  last_dq, last_dq_n;
  logic [15:0] addr_lo, addr_lo_n;
  logic [5:0]  addr_hi, addr_hi_n;
  logic [15:0] data_r, data_n;
  logic        ack_n;
  logic [15:0] dat_o_n;
  logic [21:0] fa_n;
  logic [15:0] fd_n;
  logic [15:0] rd_mux;
  logic [21:0] full_addr;
  logic [2:0]  last_step;
  logic        acc, wr, tmo_hit, bad_result;

  // Address/data of command step idx; step 5 only exists for sector erase.
  function automatic logic [37:0] cmd_word(input logic [2:0] idx, input logic erase,
                                           input logic [21:0] a, input logic [15:0] d);
    logic [37:0] r;
    case (idx)
      3'd0:    r = {22'h000555, 16'h00AA};
      3'd1:    r = {22'h0002AA, 16'h0055};
      3'd2:    r = {22'h000555, erase ? 16'h0080 : 16'h00A0};
      3'd3:    r = erase ? {22'h000555, 16'h00AA} : {a, d};
      3'd4:    r = {22'h0002AA, 16'h0055};
      default: r = {a, 16'h0030};
    endcase
    return r;
  endfunction

  // {ce_n, we_n, oe_n, data_oe} for each state; registered so pads never glitch.
  function automatic logic [3:0] pad_ctl(input logic [3:0] s);
    logic [3:0] r;
    case (s)
      W_SU, W_HLD: r = 4'b0111;
      W_LO:        r = 4'b0011;
      P_RD:        r = 4'b0100;
      default:     r = 4'b1110;
    endcase
    return r;
  endfunction

  assign flash_rst_n_ = 1'b1;
  assign full_addr    = {addr_hi, addr_lo};
  assign last_step    = is_erase ? 3'd5 : 3'd3;
  assign acc          = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr           = acc & wb_we_i & (wb_sel_i == 2'b11);
  assign tmo_hit      = (tmo_cnt == TMO_L);
  assign bad_result   = is_erase ? (flash_data_i_ != 16'hFFFF) : (flash_data_i_ != data_r);

  always_comb begin
    rd_mux = '0;
    case (wb_adr_i)
      2'd0: rd_mux = addr_lo;
      2'd1: rd_mux = {10'd0, addr_hi};
      2'd2: rd_mux = data_r;
      2'd3: rd_mux = {last_dq, 5'd0, err, done, busy};
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    step_n     = step;
    tmo_n      = tmo_cnt;
    is_erase_n = is_erase;
    f0_n       = f0;
    first_n    = first;
    extra_n    = extra;
    prev6_n    = prev6;
    busy_n     = busy;
    done_n     = done;
    err_n      = err;
    last_dq_n  = last_dq;
    addr_lo_n  = addr_lo;
    addr_hi_n  = addr_hi;
    data_n     = data_r;
    fa_n       = flash_addr_;
    fd_n       = flash_data_o_;
    ack_n      = acc;
    dat_o_n    = acc ? rd_mux : wb_dat_o;

    case (state)
      W_SU: begin
        if (cnt == SU_L) begin
          state_n = W_LO;
          cnt_n   = '0;
        end else cnt_n = cnt + 8'd1;
      end
      W_LO: begin
        if (cnt == WE_L) begin
          state_n = W_HLD;
          cnt_n   = '0;
        end else cnt_n = cnt + 8'd1;
      end
      W_HLD: begin
        if (cnt == HLD_L) begin
          cnt_n = '0;
          if (f0) state_n = DONE;
          else if (step == last_step) begin
            state_n = P_RD;
            fa_n    = full_addr;
          end else state_n = W_GAP;
        end else cnt_n = cnt + 8'd1;
      end
      W_GAP: begin
        step_n         = step + 3'd1;
        {fa_n, fd_n}   = cmd_word(step + 3'd1, is_erase, full_addr, data_r);
        state_n        = W_SU;
      end
      P_RD: begin
        tmo_n = tmo_cnt + 32'd1;
        if (tmo_hit) begin
          err_n   = 1'b1;
          state_n = RST_W;
        end else if (cnt == RD_L) begin
          cnt_n     = '0;
          last_dq_n = flash_data_i_[7:0];
          prev6_n   = flash_data_i_[6];
          state_n   = P_GAP;
          // A stable DQ6 means the embedded algorithm finished; DQ5 buys exactly one retry.
          if (first) first_n = 1'b0;
          else if (flash_data_i_[6] == prev6) begin
            if (bad_result) begin
              err_n   = 1'b1;
              state_n = RST_W;
            end else begin
              done_n  = 1'b1;
              state_n = DONE;
            end
          end else if (extra) begin
            err_n   = 1'b1;
            state_n = RST_W;
          end else if (flash_data_i_[5]) extra_n = 1'b1;
        end else cnt_n = cnt + 8'd1;
      end
      P_GAP: begin
        tmo_n = tmo_cnt + 32'd1;
        if (tmo_hit) begin
          err_n   = 1'b1;
          state_n = RST_W;
        end else begin
          state_n = P_RD;
          cnt_n   = '0;
        end
      end
      RST_W: begin
        f0_n    = 1'b1;
        fa_n    = full_addr;
        fd_n    = 16'h00F0;
        cnt_n   = '0;
        state_n = W_SU;
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (wr && !busy) begin
      case (wb_adr_i)
        2'd0: addr_lo_n = wb_dat_i;
        2'd1: addr_hi_n = wb_dat_i[5:0];
        2'd2: data_n    = wb_dat_i;
        default: begin
          if (wb_dat_i[1] ^ wb_dat_i[0]) begin
            busy_n       = 1'b1;
            done_n       = 1'b0;
            err_n        = 1'b0;
            is_erase_n   = wb_dat_i[1];
            f0_n         = 1'b0;
            first_n      = 1'b1;
            extra_n      = 1'b0;
            tmo_n        = '0;
            step_n       = '0;
            cnt_n        = '0;
            {fa_n, fd_n} = cmd_word(3'd0, wb_dat_i[1], full_addr, data_r);
            state_n      = W_SU;
          end
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state          <= IDLE;
      cnt            <= '0;
      step           <= '0;
      tmo_cnt        <= '0;
      is_erase       <= 1'b0;
      f0             <= 1'b0;
      first          <= 1'b0;
      extra          <= 1'b0;
      prev6          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      last_dq        <= '0;
      addr_lo        <= '0;
      addr_hi        <= '0;
      data_r         <= '0;
      wb_ack_o       <= 1'b0;
      wb_dat_o       <= '0;
      flash_addr_    <= '0;
      flash_data_o_  <= '0;
      flash_ce_n_    <= 1'b1;
      flash_we_n_    <= 1'b1;
      flash_oe_n_    <= 1'b1;
      flash_data_oe_ <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      step           <= step_n;
      tmo_cnt        <= tmo_n;
      is_erase       <= is_erase_n;
      f0             <= f0_n;
      first          <= first_n;
      extra          <= extra_n;
      prev6          <= prev6_n;
      busy           <= busy_n;
      done           <= done_n;
      err            <= err_n;
      last_dq        <= last_dq_n;
      addr_lo        <= addr_lo_n;
      addr_hi        <= addr_hi_n;
      data_r         <= data_n;
      wb_ack_o       <= ack_n;
      wb_dat_o       <= dat_o_n;
      flash_addr_    <= fa_n;
      flash_data_o_  <= fd_n;
      {flash_ce_n_, flash_we_n_, flash_oe_n_, flash_data_oe_} <= pad_ctl(state_n);
    end
  end

endmodule

// File: tb/tb_flash_prog.sv
// Self-checking bench for flash_prog: behavioural flash model plus a reference of the
// command sequence and DQ6/DQ5 polling outcome derived from the command-set rules.
module tb_flash_prog;
  localparam int unsigned T_SU  = 1;
  localparam int unsigned T_WE  = 4;
  localparam int unsigned T_HLD = 2;
  localparam int unsigned T_RD  = 5;
  localparam int unsigned TMO   = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wb_dat_i, wb_dat_o;
  logic [2:1]  wb_adr;
  logic        wb_we, wb_stb, wb_cyc, wb_ack;
  logic [1:0]  wb_sel;
  logic [21:0] flash_addr;
  logic [15:0] flash_data_i, flash_data_o;
  logic        flash_data_oe, flash_we_n, flash_oe_n, flash_ce_n, flash_rst_n;

  always #5 clk = ~clk;

  flash_prog #(.T_SU(T_SU), .T_WE(T_WE), .T_HLD(T_HLD), .T_RD(T_RD), .TMO(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_adr_i(wb_adr), .wb_we_i(wb_we), .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc),
    .wb_sel_i(wb_sel), .wb_ack_o(wb_ack), .flash_addr_(flash_addr),
    .flash_data_i_(flash_data_i), .flash_data_o_(flash_data_o),
    .flash_data_oe_(flash_data_oe), .flash_we_n_(flash_we_n), .flash_oe_n_(flash_oe_n),
    .flash_ce_n_(flash_ce_n), .flash_rst_n_(flash_rst_n));

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Flash model: read k returns toggling status (DQ6 = k[0], DQ5 = dq5) while k < ntog, then fin.
  logic [31:0] m_ntog = '0;
  logic        m_dq5 = 1'b0;
  logic [15:0] m_fin = '0;
  logic [31:0] reads = '0;

  function automatic logic [15:0] fsample(input logic [31:0] k, input logic [31:0] ntog,
                                          input logic dq5, input logic [15:0] fin);
    return (k < ntog) ? {9'd0, k[0], dq5, 5'd0} : fin;
  endfunction

  always_comb flash_data_i = fsample(reads, m_ntog, m_dq5, m_fin);

  // Bus monitor: captures every completed write pulse and read strobe on the pads.
  logic        mon_en = 1'b0;
  logic        tmo_mode = 1'b0;
  int          we_lo = 0, rd_lo = 0, first_rd = 0;
  logic        wr_bad = 1'b0;
  logic [21:0] cap_a;
  logic [15:0] cap_d;
  logic [21:0] wr_a[$];
  logic [15:0] wr_d[$];
  int          wr_t[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!mon_en) begin
      we_lo = 0;
      rd_lo = 0;
      wr_bad = 1'b0;
    end else begin
      if (!flash_we_n) begin
        we_lo++;
        cap_a = flash_addr;
        cap_d = flash_data_o;
        if (flash_ce_n || !flash_data_oe || !flash_oe_n) wr_bad = 1'b1;
      end else if (we_lo != 0) begin
        wr_a.push_back(cap_a);
        wr_d.push_back(cap_d);
        wr_t.push_back(cyc);
        chk("we_width", 48'(we_lo), 48'(T_WE));
        chk("we_ctl", 48'(wr_bad), 48'd0);
        we_lo = 0;
        wr_bad = 1'b0;
      end
      if (!flash_oe_n) begin
        if (rd_lo == 0 && reads == 0) first_rd = cyc;
        rd_lo++;
      end else if (rd_lo != 0) begin
        if (!tmo_mode) chk("rd_width", 48'(rd_lo), 48'(T_RD));
        rd_lo = 0;
        reads = reads + 32'd1;
      end
    end
  end

  task automatic wb_cycle(input logic [1:0] a, input logic we, input logic [15:0] d,
                          input logic [1:0] sel, output logic [15:0] q);
    @(negedge clk);
    wb_adr = a; wb_we = we; wb_dat_i = d; wb_sel = sel; wb_stb = 1'b1; wb_cyc = 1'b1;
    @(negedge clk);
    chk("ack_rise", 48'(wb_ack), 48'd1);
    q = wb_dat_o;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    chk("ack_fall", 48'(wb_ack), 48'd0);
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [15:0] d);
    logic [15:0] q;
    wb_cycle(a, 1'b1, d, 2'b11, q);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [15:0] q);
    wb_cycle(a, 1'b0, 16'h0000, 2'b11, q);
  endtask

  task automatic wait_idle(output logic [15:0] st);
    st = 16'h0001;
    for (int i = 0; i < 2000 && st[0]; i++) wb_read(2'd3, st);
    chk("completes", 48'(st[0]), 48'd0);
  endtask

  // Reference outcome of the polling rules over the model's sample stream.
  function automatic void ref_poll(input bit erase, input logic [15:0] d, input logic [31:0] ntog,
                                   input bit dq5, input logic [15:0] fin,
                                   output bit e, output int n, output logic [15:0] last);
    logic [15:0] s, p;
    bit armed;
    armed = 1'b0; e = 1'b1; n = 0; last = '0; p = '0;
    for (int k = 0; k < 64; k++) begin
      s = fsample(32'(k), ntog, dq5, fin);
      n = k + 1;
      last = s;
      if (k == 0) p = s;
      else if (s[6] == p[6]) begin
        e = erase ? (s != 16'hFFFF) : (s != d);
        return;
      end else if (armed) begin
        e = 1'b1;
        return;
      end else begin
        armed = s[5];
        p = s;
      end
    end
  endfunction

  task automatic start_op(input bit erase, input logic [21:0] a, input logic [15:0] d,
                          input logic [31:0] ntog, input bit dq5, input logic [15:0] fin);
    m_ntog = ntog; m_dq5 = dq5; m_fin = fin; reads = '0;
    wr_a.delete(); wr_d.delete(); wr_t.delete();
    wb_write(2'd0, a[15:0]);
    wb_write(2'd1, {10'd0, a[21:16]});
    wb_write(2'd2, d);
    wb_write(2'd3, erase ? 16'h0002 : 16'h0001);
  endtask

  task automatic run_op(input bit erase, input logic [21:0] a, input logic [15:0] d,
                        input logic [31:0] ntog, input bit dq5, input logic [15:0] fin,
                        input bit poke);
    logic [15:0] st, q;
    logic [21:0] ea[$];
    logic [15:0] ed[$];
    bit e;
    int n;
    logic [15:0] last;
    start_op(erase, a, d, ntog, dq5, fin);
    wb_read(2'd3, st);
    chk("busy_after_start", 48'(st[2:0]), 48'h1);
    if (poke) begin
      wb_write(2'd2, ~d);
      wb_write(2'd3, 16'h0002);
      wb_write(2'd0, ~a[15:0]);
    end
    wait_idle(st);
    ref_poll(erase, d, ntog, dq5, fin, e, n, last);
    ea = '{22'h000555, 22'h0002AA, 22'h000555};
    ed = '{16'h00AA, 16'h0055, erase ? 16'h0080 : 16'h00A0};
    if (erase) begin
      ea.push_back(22'h000555); ed.push_back(16'h00AA);
      ea.push_back(22'h0002AA); ed.push_back(16'h0055);
      ea.push_back(a);          ed.push_back(16'h0030);
    end else begin
      ea.push_back(a);          ed.push_back(d);
    end
    if (e) begin
      ea.push_back(a); ed.push_back(16'h00F0);
    end
    chk("stat", 48'(st), 48'({last[7:0], 5'd0, e, !e, 1'b0}));
    chk("n_reads", 48'(reads), 48'(n));
    chk("n_writes", 48'(wr_a.size()), 48'(ea.size()));
    for (int i = 0; i < ea.size() && i < wr_a.size(); i++)
      chk($sformatf("write%0d", i), {2'b00, wr_a[i], wr_d[i]}, {2'b00, ea[i], ed[i]});
    if (poke) begin
      wb_read(2'd2, q);
      chk("data_kept", 48'(q), 48'(d));
      wb_read(2'd0, q);
      chk("addr_kept", 48'(q), 48'(a[15:0]));
    end
  endtask

  initial begin
    logic [15:0] q, st;
    bit r_er, r_q5;
    logic [21:0] r_a;
    logic [15:0] r_d, r_fin;
    logic [31:0] r_nt;

    rst = 1'b1; wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    wb_sel = 2'b00; wb_adr = 2'd0; wb_dat_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_pads", 48'({flash_ce_n, flash_we_n, flash_oe_n, flash_data_oe, flash_rst_n}), 48'b11101);
    chk("rst_addr", 48'(flash_addr), 48'd0);
    chk("rst_ack", 48'(wb_ack), 48'd0);
    @(negedge clk);
    rst = 1'b0;
    wb_read(2'd3, q);
    chk("rst_stat", 48'(q), 48'd0);

    // Asynchronous reset while WE is low abandons the operation on the spot.
    start_op(1'b0, 22'h012345, 16'hBEEF, 32'd3, 1'b0, 16'hBEEF);
    for (int i = 0; i < 50 && flash_we_n; i++) @(negedge clk);
    chk("reached_we_low", 48'(flash_we_n), 48'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pads", 48'({flash_ce_n, flash_we_n, flash_oe_n, flash_data_oe}), 48'b1110);
    @(negedge clk);
    rst = 1'b0;
    wb_read(2'd3, q);
    chk("async_rst_stat", 48'(q), 48'd0);
    wb_read(2'd2, q);
    chk("async_rst_data", 48'(q), 48'd0);

    mon_en = 1'b1;
    run_op(1'b0, 22'h012345, 16'hBEEF, 32'd3, 1'b0, 16'hBEEF, 1'b0);
    run_op(1'b1, 22'h010000, 16'h0000, 32'd4, 1'b0, 16'hFFFF, 1'b0);
    run_op(1'b0, 22'h012345, 16'hBEEF, 32'd2, 1'b0, 16'hBEEE, 1'b0);
    run_op(1'b0, 22'h2ABCDE, 16'h1357, 32'hFFFF_FFFF, 1'b1, 16'h0000, 1'b0);
    run_op(1'b0, 22'h155AA5, 16'hC3A5, 32'd1, 1'b0, 16'hC3A5, 1'b1);

    wb_cycle(2'd2, 1'b1, 16'h5555, 2'b01, q);
    wb_read(2'd2, q);
    chk("sel01_ignored", 48'(q), 48'hC3A5);

    for (int it = 0; it < 8; it++) begin
      r_er  = 1'($urandom_range(0, 1));
      r_a   = 22'($urandom);
      r_d   = 16'($urandom);
      r_nt  = 32'($urandom_range(0, 5));
      r_q5  = ($urandom_range(0, 3) == 0);
      r_fin = ($urandom_range(0, 3) != 0) ? (r_er ? 16'hFFFF : r_d) : 16'($urandom);
      run_op(r_er, r_a, r_d, r_nt, r_q5, r_fin, 1'b0);
    end

    // Endless toggling with DQ5 low only ends through the polling timeout.
    tmo_mode = 1'b1;
    start_op(1'b0, 22'h034321, 16'h0F0F, 32'hFFFF_FFFF, 1'b0, 16'h0000);
    wait_idle(st);
    chk("tmo_stat", 48'(st[2:0]), 48'b100);
    chk("tmo_nwr", 48'(wr_a.size()), 48'd5);
    if (wr_a.size() > 0) begin
      chk("tmo_f0", {2'b00, wr_a[wr_a.size()-1], wr_d[wr_d.size()-1]}, {2'b00, 22'h034321, 16'h00F0});
      chk("tmo_latency", 48'(wr_t[wr_t.size()-1] - first_rd), 48'(TMO + 1 + T_SU + T_WE));
    end

    if (fails != 0) $display("%0d comparisons did not match", fails);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
